// File: rtl/mmio_uart_responder_pkg.sv
// Shared constants for the CPU IO page responder: page bit, register offsets,
// STATUS bit positions and the UART transmitter state encoding.
package mmio_uart_responder_pkg;

   localparam int IO_PAGE_BIT = 22;

   localparam logic [1:0] OFF_LEDS        = 2'd0;
   localparam logic [1:0] OFF_UART_DATA   = 2'd1;
   localparam logic [1:0] OFF_UART_STATUS = 2'd2;

   localparam int STAT_BUSY = 0;
   localparam int STAT_FULL = 1;
   localparam int STAT_OVF  = 2;

   typedef enum logic [1:0] {
      TX_IDLE  = 2'd0,
      TX_START = 2'd1,
      TX_DATA  = 2'd2,
      TX_STOP  = 2'd3
   } tx_state_t;

   // Clocks per UART bit; never below 2 so the bit counter has a real range.
   function automatic int baud_div(input int clk_hz, input int baud);
      int d;
      d = clk_hz / baud;
      return (d < 2) ? 2 : d;
   endfunction

endpackage

// File: rtl/mmio_uart_responder_if.sv
// Processor-side memory bus as seen by the IO page responder.
interface mmio_uart_responder_if;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_wmask;
   logic        mem_rstrb;
   logic [31:0] mem_rdata;

   modport master (
      output mem_addr, mem_wdata, mem_wmask, mem_rstrb,
      input  mem_rdata
   );

   modport slave (
      input  mem_addr, mem_wdata, mem_wmask, mem_rstrb,
      output mem_rdata
   );
endinterface

// File: rtl/mmio_uart_responder_uart_tx_core.sv
// 8N1 transmitter: baud counter, shift register and START/DATA/STOP sequencer.
// The byte is taken (in_ready) at the end of the start bit, so in_data must be held until then.
module uart_tx_core
   import mmio_uart_responder_pkg::*;
#(
   parameter int DIV = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       in_valid,
   input  logic [7:0] in_data,
   output logic       in_ready,
   output logic       txd,
   output logic       idle
);

   localparam int CW = (DIV > 2) ? $clog2(DIV) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);

   tx_state_t      state_reg, state_next;
   logic [CW-1:0]  cnt_reg, cnt_next;
   logic [2:0]     bit_reg, bit_next;
   logic [7:0]     shift_reg, shift_next;
   logic           tick;

   assign tick = (cnt_reg == CNT_LAST);

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg <= TX_IDLE;
         cnt_reg   <= '0;
         bit_reg   <= '0;
         shift_reg <= '0;
      end else begin
         state_reg <= state_next;
         cnt_reg   <= cnt_next;
         bit_reg   <= bit_next;
         shift_reg <= shift_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      bit_next   = bit_reg;
      shift_next = shift_reg;
      in_ready   = 1'b0;
      cnt_next   = (state_reg == TX_IDLE || tick) ? '0 : cnt_reg + 1'b1;
      case (state_reg)
         TX_IDLE: begin
            if (in_valid) state_next = TX_START;
         end
         TX_START: begin
            if (tick) begin
               in_ready   = 1'b1;
               shift_next = in_data;
               bit_next   = 3'd0;
               state_next = TX_DATA;
            end
         end
         TX_DATA: begin
            if (tick) begin
               shift_next = shift_reg >> 1;
               if (bit_reg == 3'd7) state_next = TX_STOP;
               else                 bit_next   = bit_reg + 1'b1;
            end
         end
         TX_STOP: begin
            // Chain straight into the next start bit when another byte waits.
            if (tick) state_next = in_valid ? TX_START : TX_IDLE;
         end
         default: state_next = TX_IDLE;
      endcase
   end

   always_comb begin
      txd = 1'b1;
      case (state_reg)
         TX_START: txd = 1'b0;
         TX_DATA:  txd = shift_reg[0];
         default:  txd = 1'b1;
      endcase
   end

   assign idle = (state_reg == TX_IDLE);

endmodule

// File: rtl/mmio_uart_responder.sv
// CPU IO page responder: LED register, UART data/status registers and TX byte queue.
// MMIO_TX_FIFO_EN selects a 4-entry TX FIFO; otherwise a single holding register.
module mmio_uart_responder
   import mmio_uart_responder_pkg::*;
#(
   parameter int CLK_FREQ_HZ = 10_000_000,
   parameter int BAUD_RATE   = 115200,
   parameter int LED_W       = 5
) (
   input  logic               clk,
   input  logic               reset,
   mmio_uart_responder_if.slave bus,
   output logic [LED_W-1:0]   leds,
   output logic               txd
);

   localparam int DIV = baud_div(CLK_FREQ_HZ, BAUD_RATE);

   logic [1:0]       offset;
   logic             io_sel, wr_en, rd_en, data_wr, stat_wr;
   logic [LED_W-1:0] leds_reg;
   logic [31:0]      rdata_reg, rd_value, status_word;
   logic             ovf_reg;
   logic             tx_valid, tx_ready, core_idle;
   logic [7:0]       tx_data;
   logic             pending, busy, full, push, pop, drop;
   logic             unused_bits;

   assign io_sel  = bus.mem_addr[IO_PAGE_BIT];
   assign offset  = bus.mem_addr[3:2];
   assign wr_en   = io_sel & bus.mem_wmask[0];
   assign rd_en   = io_sel & bus.mem_rstrb;
   assign data_wr = wr_en & (offset == OFF_UART_DATA);
   assign stat_wr = wr_en & (offset == OFF_UART_STATUS);
   assign unused_bits = ^{bus.mem_addr[31:23], bus.mem_addr[21:4], bus.mem_addr[1:0],
                          bus.mem_wdata[31:8], bus.mem_wmask[3:1]};

   assign pop = tx_valid & tx_ready;

`ifdef MMIO_TX_FIFO_EN
   logic [7:0] fifo_mem [4];
   logic [1:0] wr_ptr_reg, rd_ptr_reg;
   logic [2:0] count_reg;

   assign full     = (count_reg == 3'd4);
   assign push     = data_wr & (~full | pop);
   assign tx_valid = (count_reg != 3'd0);
   assign tx_data  = fifo_mem[rd_ptr_reg];
   assign pending  = tx_valid;

   always_ff @(posedge clk) begin
      if (push) fifo_mem[wr_ptr_reg] <= bus.mem_wdata[7:0];
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
         if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
         count_reg <= count_reg + {2'b00, push} - {2'b00, pop};
      end
   end
`else
   logic       hold_valid_reg;
   logic [7:0] hold_data_reg;

   assign pending  = hold_valid_reg;
   assign full     = busy;
   assign push     = data_wr & ~busy;
   assign tx_valid = hold_valid_reg;
   assign tx_data  = hold_data_reg;

   always_ff @(posedge clk) begin
      if (reset) begin
         hold_valid_reg <= 1'b0;
         hold_data_reg  <= '0;
      end else if (push) begin
         hold_valid_reg <= 1'b1;
         hold_data_reg  <= bus.mem_wdata[7:0];
      end else if (pop) begin
         hold_valid_reg <= 1'b0;
      end
   end
`endif

   assign busy = ~core_idle | pending;
   assign drop = data_wr & ~push;

   uart_tx_core #(.DIV(DIV)) u_tx (
      .clk      (clk),
      .reset    (reset),
      .in_valid (tx_valid),
      .in_data  (tx_data),
      .in_ready (tx_ready),
      .txd      (txd),
      .idle     (core_idle)
   );

   always_comb begin
      status_word            = '0;
      status_word[STAT_BUSY] = busy;
      status_word[STAT_FULL] = full;
      status_word[STAT_OVF]  = ovf_reg;
   end

   // Read value is built from pre-edge register state, so a same-edge write is not visible yet.
   always_comb begin
      rd_value = '0;
      case (offset)
         OFF_LEDS:        rd_value[LED_W-1:0] = leds_reg;
         OFF_UART_STATUS: rd_value = status_word;
         default:         rd_value = '0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rdata_reg <= '0;
         leds_reg  <= '0;
         ovf_reg   <= 1'b0;
      end else begin
         if (rd_en) rdata_reg <= rd_value;
         if (wr_en && offset == OFF_LEDS) leds_reg <= bus.mem_wdata[LED_W-1:0];
         if (drop)
            ovf_reg <= 1'b1;
         else if (stat_wr && bus.mem_wdata[STAT_OVF])
            ovf_reg <= 1'b0;
      end
   end

   assign bus.mem_rdata = rdata_reg;
   assign leds          = leds_reg;

endmodule

// File: tb/tb_mmio_uart_responder.sv
// Directed bench for mmio_uart_responder at DIV=4 (400 Hz clock, 100 baud).
// Honours MMIO_TX_FIFO_EN for the FIFO-dependent expectations.
module tb_mmio_uart_responder;

   localparam logic [31:0] A_LEDS   = 32'h0040_0000;
   localparam logic [31:0] A_DATA   = 32'h0040_0004;
   localparam logic [31:0] A_STATUS = 32'h0040_0008;
   localparam logic [31:0] A_RSVD   = 32'h0040_000C;
`ifdef MMIO_TX_FIFO_EN
   localparam int          NFRAMES4  = 4;
   localparam logic [31:0] STAT_MID  = 32'h1;
`else
   localparam int          NFRAMES4  = 1;
   localparam logic [31:0] STAT_MID  = 32'h3;
`endif

   logic       clk = 1'b0;
   logic       reset;
   logic [4:0] leds;
   logic       txd;
   int         total = 0;
   int         bad = 0;
   logic [31:0] rd;
   logic        saw_low;

   mmio_uart_responder_if bus();

   mmio_uart_responder #(.CLK_FREQ_HZ(400), .BAUD_RATE(100), .LED_W(5)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus),
      .leds  (leds),
      .txd   (txd)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic frame_bit(input logic [7:0] b, input int idx);
      if (idx == 0) return 1'b0;
      if (idx >= 9) return 1'b1;
      return b[idx-1];
   endfunction

   // Test 4 expectation: sample t shows the line after edge N+t-1; frames start at t=2.
   function automatic logic exp4(input int t);
      int j;
      j = t - 2;
      if (j < 0 || j / 40 >= NFRAMES4) return 1'b1;
      return frame_bit(8'(j / 40 + 1), (j % 40) / 4);
   endfunction

   task automatic bus_idle();
      bus.mem_addr  = '0;
      bus.mem_wdata = '0;
      bus.mem_wmask = '0;
      bus.mem_rstrb = 1'b0;
   endtask

   task automatic bus_wr(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] mask);
      bus.mem_addr  = addr;
      bus.mem_wdata = data;
      bus.mem_wmask = mask;
      bus.mem_rstrb = 1'b0;
      @(posedge clk);
      @(negedge clk);
      bus_idle();
      $display("wr addr=%h data=%h mask=%b", addr, data, mask);
   endtask

   task automatic bus_rd(input logic [31:0] addr, output logic [31:0] data);
      bus.mem_addr  = addr;
      bus.mem_rstrb = 1'b1;
      @(posedge clk);
      @(negedge clk);
      data = bus.mem_rdata;
      bus_idle();
      $display("rd addr=%h data=%h", addr, data);
   endtask

   task automatic wait_start(input string tag);
      for (int i = 0; i < 20 && txd !== 1'b0; i++) @(negedge clk);
      check(tag, 32'(txd), 32'h0);
   endtask

   initial begin
      reset = 1'b1;
      bus_idle();
      repeat (3) @(negedge clk);
      reset = 1'b0;

      // 1: reset state
      check("t1_rdata_reset", bus.mem_rdata, 32'h0);
      check("t1_txd_reset", 32'(txd), 32'h1);
      check("t1_leds_reset", 32'(leds), 32'h0);
      bus_rd(A_STATUS, rd);
      check("t1_status", rd, 32'h0);

      // 2: LED write and readback
      bus_wr(A_LEDS, 32'h15, 4'b0001);
      check("t2_leds", 32'(leds), 32'h15);
      bus_rd(A_LEDS, rd);
      check("t2_leds_rd", rd, 32'h15);

      // 3: single frame 0xA5, STATUS polled mid-frame
      bus_wr(A_DATA, 32'hA5, 4'b0001);
      wait_start("t3_start_seen");
      for (int i = 0; i < 40; i++) begin
         check($sformatf("t3_bit%0d_s%0d", i / 4, i % 4), 32'(txd), 32'(frame_bit(8'hA5, i / 4)));
         if (i == 21) check("t3_busy_mid", bus.mem_rdata, STAT_MID);
         if (i == 20) begin
            bus.mem_addr  = A_STATUS;
            bus.mem_rstrb = 1'b1;
         end else begin
            bus_idle();
         end
         @(negedge clk);
      end
      check("t3_txd_idle", 32'(txd), 32'h1);
      bus_rd(A_STATUS, rd);
      check("t3_status_done", rd, 32'h0);

      // 4: five back-to-back writes 0x01..0x05
      for (int t = 0; t < 200; t++) begin
         check($sformatf("t4_t%0d", t), 32'(txd), 32'(exp4(t)));
         if (t < 5) begin
            bus.mem_addr  = A_DATA;
            bus.mem_wdata = 32'(t + 1);
            bus.mem_wmask = 4'b0001;
         end else begin
            bus_idle();
         end
         @(negedge clk);
      end
      bus_rd(A_STATUS, rd);
      check("t4_ovf_set", rd, 32'h4);
      bus_wr(A_STATUS, 32'h0, 4'b0001);
      bus_rd(A_STATUS, rd);
      check("t4_ovf_w0_keeps", rd, 32'h4);
      bus_wr(A_STATUS, 32'h4, 4'b0001);
      bus_rd(A_STATUS, rd);
      check("t4_ovf_w1c", rd, 32'h0);

      // 5: reset during data bit 3
      bus_wr(A_DATA, 32'hA5, 4'b0001);
      wait_start("t5_start_seen");
      repeat (16) @(negedge clk);
      check("t5_bit3_before_reset", 32'(txd), 32'h0);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      check("t5_txd_after_reset", 32'(txd), 32'h1);
      check("t5_leds_after_reset", 32'(leds), 32'h0);
      check("t5_rdata_after_reset", bus.mem_rdata, 32'h0);
      bus_rd(A_STATUS, rd);
      check("t5_status", rd, 32'h0);
      saw_low = 1'b0;
      for (int i = 0; i < 80; i++) begin
         if (txd !== 1'b1) saw_low = 1'b1;
         @(negedge clk);
      end
      check("t5_no_frame", 32'(saw_low), 32'h0);

      // 6: non-IO accesses, lane masking, read-only/reserved offsets, same-edge read+write
      bus_wr(A_LEDS, 32'h0B, 4'b0001);
      bus_rd(A_LEDS, rd);
      check("t6_leds_rd", rd, 32'h0B);
      bus_wr(32'h0000_0000, 32'hFF, 4'b1111);
      check("t6_nonio_wr_leds", 32'(leds), 32'h0B);
      bus_rd(32'h0000_0000, rd);
      check("t6_nonio_rd_hold", rd, 32'h0B);
      bus_wr(A_LEDS, 32'h1F, 4'b0010);
      check("t6_lane1_ignored", 32'(leds), 32'h0B);
      bus.mem_addr  = A_LEDS;
      bus.mem_wdata = 32'h1F;
      bus.mem_wmask = 4'b0001;
      bus.mem_rstrb = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus_idle();
      $display("rw addr=%h data=%h", A_LEDS, 32'h1F);
      check("t6_rw_old_value", bus.mem_rdata, 32'h0B);
      check("t6_rw_leds_new", 32'(leds), 32'h1F);
      bus_rd(A_DATA, rd);
      check("t6_data_reads0", rd, 32'h0);
      bus_rd(A_LEDS, rd);
      check("t6_leds_rd2", rd, 32'h1F);
      bus_rd(A_RSVD, rd);
      check("t6_rsvd_reads0", rd, 32'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
